// File: rtl/alu_mem_stage.sv
// alu_mem_stage: execute/memory datapath of the single-cycle MIPS core.
//   ALU-control decoder (aluop + funct -> alu_ctl, jr detect), 32-bit ALU with
//   zero flag, and a word-organised data memory with asynchronous read.
//
// Ports:
//   clk         memory write clock (rising edge)
//   reset       asynchronous active-low, clears the whole data memory
//   aluop       00 add, 01 sub, 10 R-type (funct), 11 or
//   funct       instruction[5:0]
//   shamt       instruction[10:6], shift amount
//   src_a/src_b ALU operands
//   store_data  write data for sw
//   memread     gates read_data (0 when low)
//   memwrite    write store_data at alu_result on clk rise
//   alu_ctl     decoded ALU operation
//   jump_reg    high for jr
//   alu_result  ALU result, also the memory byte address
//   zero        alu_result == 0
//   read_data   addressed memory word, or 0
//
// Configuration macro: ALU_SHIFT_EN builds the SLL/SRL/SRA decode and shifter.
// Without it those functs decode as ADD and shamt is unused.

module alu_mem_stage #(
    parameter int MEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  aluop,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] store_data,
    input  logic        memread,
    input  logic        memwrite,
    output logic [3:0]  alu_ctl,
    output logic        jump_reg,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] read_data
);

    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SLL = 4'b0011;
    localparam logic [3:0] CTL_SRL = 4'b0100;
    localparam logic [3:0] CTL_SRA = 4'b0101;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    // ALU control decode
    always_comb begin
        alu_ctl  = CTL_ADD;
        jump_reg = 1'b0;
        unique case (aluop)
            2'b00: alu_ctl = CTL_ADD;
            2'b01: alu_ctl = CTL_SUB;
            2'b11: alu_ctl = CTL_OR;
            2'b10: begin
                case (funct)
                    6'b100000: alu_ctl = CTL_ADD;
                    6'b100010: alu_ctl = CTL_SUB;
                    6'b100100: alu_ctl = CTL_AND;
                    6'b100101: alu_ctl = CTL_OR;
                    6'b100111: alu_ctl = CTL_NOR;
                    6'b101010: alu_ctl = CTL_SLT;
`ifdef ALU_SHIFT_EN
                    6'b000000: alu_ctl = CTL_SLL;
                    6'b000010: alu_ctl = CTL_SRL;
                    6'b000011: alu_ctl = CTL_SRA;
`endif
                    6'b001000: begin
                        alu_ctl  = CTL_ADD;
                        jump_reg = 1'b1;
                    end
                    default:   alu_ctl = CTL_ADD;
                endcase
            end
            default: alu_ctl = CTL_ADD;
        endcase
    end

    // ALU; codes without an operation (including shifts when not built) give 0
    always_comb begin
        alu_result = 32'h0;
        case (alu_ctl)
            CTL_AND: alu_result = src_a & src_b;
            CTL_OR:  alu_result = src_a | src_b;
            CTL_ADD: alu_result = src_a + src_b;
            CTL_SUB: alu_result = src_a - src_b;
            CTL_NOR: alu_result = ~(src_a | src_b);
            CTL_SLT: alu_result = {31'b0, ($signed(src_a) < $signed(src_b))};
`ifdef ALU_SHIFT_EN
            CTL_SLL: alu_result = src_b << shamt;
            CTL_SRL: alu_result = src_b >> shamt;
            CTL_SRA: alu_result = $unsigned($signed(src_b) >>> shamt);
`endif
            default: alu_result = 32'h0;
        endcase
    end

`ifndef ALU_SHIFT_EN
    logic unused_shamt;
    assign unused_shamt = ^shamt;
`endif

    assign zero = (alu_result == 32'h0);

    // Data memory: byte address -> word index; low two bits and bits above
    // the index are dropped, so addresses wrap modulo MEM_DEPTH*4.
    logic [31:0]   mem [MEM_DEPTH];
    logic [AW-1:0] mem_idx;

    assign mem_idx = alu_result[AW+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (memwrite) begin
            mem[mem_idx] <= store_data;
        end
    end

    assign read_data = memread ? mem[mem_idx] : 32'h0;

endmodule

// File: tb/tb_alu_mem_stage.sv
module tb_alu_mem_stage;

    localparam int MEM_DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] src_a, src_b, store_data;
    logic        memread, memwrite;
    logic [3:0]  alu_ctl;
    logic        jump_reg;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] read_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [MEM_DEPTH];

    alu_mem_stage #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk), .reset(reset), .aluop(aluop), .funct(funct), .shamt(shamt),
        .src_a(src_a), .src_b(src_b), .store_data(store_data),
        .memread(memread), .memwrite(memwrite), .alu_ctl(alu_ctl),
        .jump_reg(jump_reg), .alu_result(alu_result), .zero(zero),
        .read_data(read_data)
    );

    always #5 clk = ~clk;

    typedef enum {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT,
                  OP_SLL, OP_SRL, OP_SRA} op_e;

    // Reference: pick the mnemonic from aluop/funct, then evaluate it.
    function automatic void model(input logic [1:0] op, input logic [5:0] f,
                                  input logic [4:0] sh, input logic [31:0] a,
                                  input logic [31:0] b, output logic [3:0] ctl,
                                  output logic jr, output logic [31:0] res);
        op_e m;
        jr = 1'b0;
        m  = OP_ADD;
        if (op == 2'd1) m = OP_SUB;
        else if (op == 2'd3) m = OP_OR;
        else if (op == 2'd2) begin
            if (f == 6'h20) m = OP_ADD;
            else if (f == 6'h22) m = OP_SUB;
            else if (f == 6'h24) m = OP_AND;
            else if (f == 6'h25) m = OP_OR;
            else if (f == 6'h27) m = OP_NOR;
            else if (f == 6'h2A) m = OP_SLT;
            else if (f == 6'h08) jr = 1'b1;
`ifdef ALU_SHIFT_EN
            else if (f == 6'h00) m = OP_SLL;
            else if (f == 6'h02) m = OP_SRL;
            else if (f == 6'h03) m = OP_SRA;
`endif
        end
        case (m)
            OP_ADD: begin ctl = 4'd2;  res = a + b; end
            OP_SUB: begin ctl = 4'd6;  res = a - b; end
            OP_AND: begin ctl = 4'd0;  res = a & b; end
            OP_OR:  begin ctl = 4'd1;  res = a | b; end
            OP_NOR: begin ctl = 4'd12; res = ~(a | b); end
            OP_SLT: begin ctl = 4'd7;  res = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
            OP_SLL: begin ctl = 4'd3;  res = b << sh; end
            OP_SRL: begin ctl = 4'd4;  res = b >> sh; end
            default: begin ctl = 4'd5; res = 32'(int'(b) >>> sh); end
        endcase
    endfunction

    function automatic int ref_idx(input logic [31:0] addr);
        return int'((addr / 4) % MEM_DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
        aluop = op; funct = f; shamt = sh; src_a = a; src_b = b;
    endtask

    task automatic check_comb(input string tag);
        logic [3:0]  e_ctl;
        logic        e_jr;
        logic [31:0] e_res;
        model(aluop, funct, shamt, src_a, src_b, e_ctl, e_jr, e_res);
        chk({tag, ".alu_ctl"}, {28'b0, alu_ctl}, {28'b0, e_ctl});
        chk({tag, ".jump_reg"}, {31'b0, jump_reg}, {31'b0, e_jr});
        chk({tag, ".alu_result"}, alu_result, e_res);
        chk({tag, ".zero"}, {31'b0, zero}, {31'b0, (e_res == 32'h0)});
    endtask

    task automatic check_read(input string tag);
        chk(tag, read_data, memread ? ref_mem[ref_idx(src_a + src_b)] : 32'h0);
    endtask

    logic [5:0] functs [12];

    initial begin
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A,
                   6'h00, 6'h02, 6'h03, 6'h08, 6'h01, 6'h3F};
        for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = 32'h0;

        reset = 1'b0; memread = 1'b1; memwrite = 1'b0; store_data = 32'h0;
        drive(2'd0, 6'h0, 5'd0, 32'h10, 32'h4);
        #1;
        chk("reset.read_data", read_data, 32'h0);
        check_comb("reset.comb");
        @(negedge clk);
        reset = 1'b1;

        // Directed ALU cases
        drive(2'd2, 6'h22, 5'd0, 32'd5, 32'd5); #1;
        chk("sub_eq.alu_ctl", {28'b0, alu_ctl}, 32'h6);
        chk("sub_eq.result", alu_result, 32'h0);
        chk("sub_eq.zero", {31'b0, zero}, 32'h1);
        chk("sub_eq.jr", {31'b0, jump_reg}, 32'h0);
        drive(2'd2, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'd1); #1;
        chk("slt_neg.result", alu_result, 32'h1);
        chk("slt_neg.zero", {31'b0, zero}, 32'h0);
        drive(2'd2, 6'h08, 5'd0, 32'h100, 32'h0); #1;
        chk("jr.jump_reg", {31'b0, jump_reg}, 32'h1);
        chk("jr.alu_ctl", {28'b0, alu_ctl}, 32'h2);
        drive(2'd2, 6'h03, 5'd4, 32'h0, 32'h80000000); #1;
`ifdef ALU_SHIFT_EN
        chk("sra.result", alu_result, 32'hF8000000);
`else
        chk("sra_off.result", alu_result, 32'h80000000);
`endif
        drive(2'd1, 6'h0, 5'd0, 32'd3, 32'd7); #1;
        chk("aluop01.result", alu_result, 32'hFFFFFFFC);
        chk("aluop01.zero", {31'b0, zero}, 32'h0);
        drive(2'd3, 6'h0, 5'd0, 32'd3, 32'd7); #1;
        chk("aluop11.result", alu_result, 32'h7);

        // Directed memory: write at 0x14, read back incl. wrapped alias 0x116
        @(negedge clk);
        drive(2'd0, 6'h0, 5'd0, 32'h10, 32'h4);
        memwrite = 1'b1; memread = 1'b0; store_data = 32'hDEADBEEF;
        @(posedge clk);
        ref_mem[ref_idx(32'h14)] = 32'hDEADBEEF;
        @(negedge clk);
        memwrite = 1'b0; memread = 1'b1; #1;
        chk("mem.read", read_data, 32'hDEADBEEF);
        drive(2'd0, 6'h0, 5'd0, 32'h112, 32'h4); #1;
        chk("mem.alias116", read_data, 32'hDEADBEEF);
        memread = 1'b0; #1;
        chk("mem.noread", read_data, 32'h0);

        // Reset pulse between edges clears memory at once and blocks writes
        memread = 1'b1;
        drive(2'd0, 6'h0, 5'd0, 32'h10, 32'h4);
        #1;
        reset = 1'b0; #1;
        for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = 32'h0;
        chk("rst_pulse.read", read_data, 32'h0);
        check_comb("rst_pulse.comb");
        memwrite = 1'b1; store_data = 32'h12345678;
        @(posedge clk); #1;
        chk("rst_blocked.read", read_data, 32'h0);
        @(negedge clk);
        memwrite = 1'b0; reset = 1'b1; #1;
        chk("rst_release.read", read_data, 32'h0);

        // Random ALU
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a, b;
            logic [5:0]  f;
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 11)];
            drive(2'($urandom_range(0, 3)), f, 5'($urandom), a, b);
            #1;
            check_comb("rand_alu");
        end

        // Random memory traffic: read before and after each edge
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            drive(2'd0, 6'($urandom), 5'($urandom), 32'($urandom_range(0, 1023)),
                  32'($urandom_range(0, 15)));
            memwrite = 1'($urandom_range(0, 1));
            memread = ($urandom_range(0, 3) != 0);
            store_data = $urandom;
            #1;
            check_read("rand_mem.pre");
            @(posedge clk);
            if (memwrite) ref_mem[ref_idx(src_a + src_b)] = store_data;
            #1;
            check_read("rand_mem.post");
        end

        // Sweep every word to catch stray writes
        @(negedge clk);
        memwrite = 1'b0; memread = 1'b1;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            drive(2'd0, 6'h0, 5'd0, 32'(i * 4), 32'h0);
            #1;
            check_read("sweep");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
